// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams 32-bit words into IMEM from address 0 and holds
// the core in reset until the program is loaded.
// Ports: clk, reset (sync, active-high)
//        in_valid/in_ready/in_data/in_last : word stream
//        imem_we/imem_addr/imem_wdata      : IMEM write port (1-cycle latency)
//        core_reset, done, error           : core release and status
//        word_count                        : data words written
// Option: `define IMEM_BOOT_CHECKSUM_EN to treat the in_last word as an XOR
//         checksum of the data words instead of a data word.
module imem_boot_loader #(
    parameter int ADDR_W   = 8,
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [ADDR_W:0] FULL    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [7:0]      HOLD_END = 8'(RST_HOLD - 1);

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        hold_q, hold_d;
    logic              xfer;
    logic              data_xfer;
    logic              last_ok;

    assign in_ready = (state_q == S_LOAD) && !reset;
    assign xfer     = in_valid && in_ready;

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [31:0] acc_q, acc_d;

    // The last word carries the checksum and is never written.
    assign data_xfer = xfer && !in_last;
    assign last_ok   = (acc_q == in_data);
`else
    assign data_xfer = xfer;
    assign last_ok   = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
        acc_d   = acc_q;
`endif
        unique case (state_q)
            S_LOAD: begin
                if (data_xfer && (cnt_q == FULL)) begin
                    // Memory full: drop the word and abort.
                    state_d = S_ERR;
                end else begin
                    if (data_xfer) begin
                        we_d    = 1'b1;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        wdata_d = in_data;
                        cnt_d   = cnt_q + CNT_ONE;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        acc_d   = acc_q ^ in_data;
`endif
                    end
                    if (xfer && in_last) begin
                        state_d = last_ok ? S_HOLD : S_ERR;
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_END) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            S_RUN: begin
            end
            S_ERR: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = cnt_q;
    assign core_reset = (state_q != S_RUN);
    assign done       = (state_q == S_RUN);
    assign error      = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: scoreboarded IMEM writes, release timing,
// overflow on a small instance, mid-load reset and (optionally) checksum.
module tb_imem_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif

    logic        reset, in_valid, in_last, in_ready;
    logic [31:0] in_data;
    logic        imem_we, core_reset, done, error;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  word_count;

    logic        s_reset, s_valid, s_last, s_ready;
    logic [31:0] s_data;
    logic        s_we, s_core_reset, s_done, s_error;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_word_count;

    imem_boot_loader #(.ADDR_W(8), .RST_HOLD(4)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_reset(core_reset),
        .done(done), .error(error), .word_count(word_count)
    );

    imem_boot_loader #(.ADDR_W(2), .RST_HOLD(4)) u_small (
        .clk(clk), .reset(s_reset),
        .in_valid(s_valid), .in_ready(s_ready),
        .in_data(s_data), .in_last(s_last),
        .imem_we(s_we), .imem_addr(s_addr),
        .imem_wdata(s_wdata), .core_reset(s_core_reset),
        .done(s_done), .error(s_error), .word_count(s_word_count)
    );

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    int vectors = 0;
    int miscompares = 0;
    wr_t exp_q[$];
    wr_t exps_q[$];
    logic [31:0] stim[$];
    logic [31:0] prog[5] = '{32'h2001000A, 32'h20020014, 32'h20030019,
                             32'h00422020, 32'h00832820};

    always @(negedge clk) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL wr_unexpected got addr=%0d data=%h exp none",
                         imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== {e.a, e.d}) begin
                    miscompares++;
                    $display("FAIL wr_data got %0d:%h exp %0d:%h",
                             imem_addr, imem_wdata, e.a, e.d);
                end
            end
        end
        if (s_we === 1'b1) begin
            vectors++;
            if (exps_q.size() == 0) begin
                miscompares++;
                $display("FAIL s_wr_unexpected got addr=%0d data=%h exp none",
                         s_addr, s_wdata);
            end else begin
                e = exps_q.pop_front();
                if ({6'd0, s_addr, s_wdata} !== {e.a, e.d}) begin
                    miscompares++;
                    $display("FAIL s_wr_data got %0d:%h exp %0d:%h",
                             s_addr, s_wdata, e.a, e.d);
                end
            end
        end
    end

    // Program image; in checksum mode a trailing XOR word is appended.
    task automatic load_program(input bit bad_sum);
        logic [31:0] x;
        x = '0;
        stim.delete();
        foreach (prog[i]) begin
            stim.push_back(prog[i]);
            x ^= prog[i];
        end
        if (CKS) stim.push_back(bad_sum ? (x ^ 32'h1) : x);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        s_reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({imem_we, imem_addr, imem_wdata, core_reset, done, error,
             word_count, in_ready} !== {1'b0, 8'd0, 32'd0, 1'b1, 1'b0,
             1'b0, 9'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_vals got we=%b a=%0d d=%h cr=%b dn=%b er=%b wc=%0d rdy=%b",
                     imem_we, imem_addr, imem_wdata, core_reset, done,
                     error, word_count, in_ready);
        end
        reset = 1'b0; s_reset = 1'b0;
        #1;
        vectors++;
        if ({in_ready, s_ready, s_core_reset} !== 3'b111) begin
            miscompares++;
            $display("FAIL ready_after_reset got %b%b%b exp 111",
                     in_ready, s_ready, s_core_reset);
        end
    endtask

    task automatic drive_prog(input bit toggle, input int n,
                              input bit mark_last);
        bit prev;
        bit lst;
        int i;
        int cyc;
        prev = 1'b0; i = 0; cyc = 0;
        while (i < n) begin
            @(negedge clk);
            vectors++;
            if (imem_we !== prev) begin
                miscompares++;
                $display("FAIL we_timing got %b exp %b cyc %0d",
                         imem_we, prev, cyc);
            end
            lst = mark_last && (i == n - 1);
            in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            in_data  = stim[i];
            in_last  = lst;
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL in_ready_load got %b exp 1", in_ready);
            end
            prev = in_valid && !(CKS && lst);
            if (in_valid) begin
                if (!(CKS && lst)) exp_q.push_back('{8'(i), stim[i]});
                i++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_data = 32'hDEADBEEF;
        vectors++;
        if (imem_we !== prev) begin
            miscompares++;
            $display("FAIL we_last got %b exp %b", imem_we, prev);
        end
    endtask

    // Entered in the first cycle after the last transfer edge.
    task automatic check_release();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if ({core_reset, done} !== 2'b10) begin
                miscompares++;
                $display("FAIL hold_cyc%0d got cr=%b dn=%b exp cr=1 dn=0",
                         k, core_reset, done);
            end
        end
        @(negedge clk);
        vectors++;
        if ({core_reset, done, error, word_count} !==
            {1'b0, 1'b1, 1'b0, 9'd5}) begin
            miscompares++;
            $display("FAIL release got cr=%b dn=%b er=%b wc=%0d exp 0 1 0 5",
                     core_reset, done, error, word_count);
        end
    endtask

    task automatic test_stream();
        load_program(1'b0);
        drive_prog(1'b0, stim.size(), 1'b1);
        check_release();
    endtask

    task automatic test_toggle();
        load_program(1'b0);
        drive_prog(1'b1, stim.size(), 1'b1);
        check_release();
    endtask

    task automatic test_after_done();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 32'h12345678; in_last = k[0];
            #1;
            vectors++;
            if ({in_ready, imem_we, core_reset, done} !== 4'b0001) begin
                miscompares++;
                $display("FAIL after_done got rdy=%b we=%b cr=%b dn=%b exp 0 0 0 1",
                         in_ready, imem_we, core_reset, done);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset_midload();
        load_program(1'b0);
        drive_prog(1'b0, 3, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({word_count, imem_we, core_reset, in_ready} !==
            {9'd0, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL midload_reset got wc=%0d we=%b cr=%b rdy=%b",
                     word_count, imem_we, core_reset, in_ready);
        end
        reset = 1'b0;
        drive_prog(1'b0, stim.size(), 1'b1);
        check_release();
    endtask

    task automatic test_bad_checksum();
        load_program(1'b1);
        drive_prog(1'b0, stim.size(), 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if ({error, core_reset, done, in_ready} !== 4'b1100) begin
                miscompares++;
                $display("FAIL bad_cks got er=%b cr=%b dn=%b rdy=%b exp 1 1 0 0",
                         error, core_reset, done, in_ready);
            end
        end
    endtask

    task automatic test_overflow();
        bit prev;
        prev = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (s_we !== prev) begin
                miscompares++;
                $display("FAIL s_we_timing got %b exp %b", s_we, prev);
            end
            s_valid = 1'b1; s_data = prog[k]; s_last = 1'b0;
            #1;
            vectors++;
            if (s_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL s_ready_load got %b exp 1", s_ready);
            end
            prev = (k < 4);
            if (k < 4) exps_q.push_back('{8'(k), prog[k]});
        end
        @(negedge clk);
        vectors++;
        if ({s_we, s_error, s_core_reset, s_ready, s_word_count} !==
            {1'b0, 1'b1, 1'b1, 1'b0, 3'd4}) begin
            miscompares++;
            $display("FAIL overflow got we=%b er=%b cr=%b rdy=%b wc=%0d exp 0 1 1 0 4",
                     s_we, s_error, s_core_reset, s_ready, s_word_count);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s_data = ~s_data;
            #1;
            vectors++;
            if ({s_we, s_error, s_ready, s_word_count} !==
                {1'b0, 1'b1, 1'b0, 3'd4}) begin
                miscompares++;
                $display("FAIL overflow_hold got we=%b er=%b rdy=%b wc=%0d",
                         s_we, s_error, s_ready, s_word_count);
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        s_reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        test_reset();
        test_stream();
        test_after_done();
        test_reset();
        test_toggle();
        test_reset();
        test_reset_midload();
        if (CKS) begin
            test_reset();
            test_bad_checksum();
        end
        test_overflow();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q.size() + exps_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_writes got %0d pending exp 0",
                     exp_q.size() + exps_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
